// File: rtl/sum8_block_accumulator.sv
// Block accumulator: sums COUNT adder-stage results and hands the total downstream over valid/ready.
// Optional SUM8_ACC_SATURATE_EN clamps the total on overflow; otherwise it wraps modulo 2^ACC_W.
module sum8_block_accumulator #(
  parameter int DATA_W = 8,
  parameter int COUNT  = 16,
  parameter int ACC_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;
  logic               accept;
  logic [ACC_W:0]     sum_ext;
  logic [ACC_W-1:0]   acc_nx;
  logic               carry;

  // Returns {carry, next accumulator value}; in the saturating build an
  // overflowing add pins the result at full scale, and because full scale
  // plus any non-zero sum overflows again the clamp persists for the block.
  function automatic logic [ACC_W:0] fold(input logic [ACC_W:0] sum);
`ifdef SUM8_ACC_SATURATE_EN
    return {sum[ACC_W], sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0]};
`else
    return sum;
`endif
  endfunction

  assign accept  = in_valid & in_ready;
  assign sum_ext = {1'b0, acc} + (ACC_W + 1)'(in_sum);
  assign {carry, acc_nx} = fold(sum_ext);

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign busy      = (state == ACCUM);
  assign out_acc   = acc;
  assign out_ovf   = ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc   <= ACC_W'(in_sum);
            cnt   <= CNT_W'(1);
            ovf   <= 1'b0;
            state <= (COUNT == 1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= acc_nx;
            ovf <= ovf | carry;
            cnt <= cnt + CNT_W'(1);
            if (cnt + CNT_W'(1) == CNT_LAST) state <= HOLD;
          end
        end
        HOLD: begin
          // acc/ovf stay visible until the next block's first accept
          if (out_ready) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
